// File: rtl/kanagawa_fifo_write_arbiter.sv
// kanagawa_fifo_write_arbiter: credit-gated round-robin arbiter sharing one FIFO write port.
// Optional sticky overflow/underflow checker enabled by KANAGAWA_FIFO_ARB_CHECK_EN.
module kanagawa_fifo_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid_in,
   input  logic [NUM_REQ*WIDTH-1:0] req_data_in,
   output logic [NUM_REQ-1:0]       req_ready_out,
   output logic                     fifo_wren_out,
   output logic [WIDTH-1:0]         fifo_wdata_out,
   input  logic                     fifo_rden_in,
   input  logic                     fifo_full_in,
   output logic [CW-1:0]            credits_out,
   output logic [1:0]               error_out
);
   logic [CW-1:0] r_credits;
   logic [PW-1:0] r_ptr;
   logic r_wren;
   logic [WIDTH-1:0] r_wdata;
   logic [NUM_REQ-1:0] w_grant;
   logic [PW-1:0] w_gidx, w_j, w_next_ptr;
   logic [PW:0] w_sum;
   logic [WIDTH-1:0] w_data;
   logic w_any;
   // Scan ptr, ptr+1, ... with wrap; first valid wins, only while a credit is held.
   always_comb begin
      w_grant = '0;
      w_gidx = '0;
      w_sum = '0;
      w_j = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_ptr} + (PW+1)'(k);
         w_j = (w_sum >= (PW+1)'(NUM_REQ)) ? PW'(w_sum - (PW+1)'(NUM_REQ)) : PW'(w_sum);
         if (w_grant == '0 && req_valid_in[w_j] && r_credits != '0) begin
            w_grant[w_j] = 1'b1;
            w_gidx = w_j;
         end
      end
   end
   always_comb begin
      w_data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         w_data = w_data | ({WIDTH{w_grant[i]}} & req_data_in[i*WIDTH +: WIDTH]);
   end
   assign w_any = |w_grant;
   assign w_next_ptr = (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
         r_wren <= 1'b0;
         r_wdata <= '0;
         r_credits <= CW'(DEPTH);
      end else begin
         r_wren <= w_any;
         if (w_any) begin
            r_ptr <= w_next_ptr;
            r_wdata <= w_data;
         end
         if (w_any && !fifo_rden_in)
            r_credits <= r_credits - 1'b1;
         else if (!w_any && fifo_rden_in && r_credits != CW'(DEPTH))
            r_credits <= r_credits + 1'b1;
      end
   end
   assign req_ready_out = w_grant;
   assign fifo_wren_out = r_wren;
   assign fifo_wdata_out = r_wdata;
   assign credits_out = r_credits;
`ifdef KANAGAWA_FIFO_ARB_CHECK_EN
   logic [1:0] r_err;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_err <= 2'b00;
      else
         r_err <= r_err | {fifo_rden_in && r_credits == CW'(DEPTH), r_wren && fifo_full_in};
   end
   assign error_out = r_err;
`else
   logic w_unused;
   assign w_unused = fifo_full_in;
   assign error_out = 2'b00;
`endif
endmodule

// File: tb/tb_kanagawa_fifo_write_arbiter.sv
// tb_kanagawa_fifo_write_arbiter: directed checks of arbitration, credits, checker and reset.
module tb_kanagawa_fifo_write_arbiter;
`ifdef KANAGAWA_FIFO_ARB_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic clk = 1'b0, rst, run;
   logic [3:0] valid, ready;
   logic [127:0] data;
   logic wren, rden, full;
   logic [31:0] wdata;
   logic [5:0] credits;
   logic [1:0] err;
   int n_chk = 0, n_bad = 0;

   kanagawa_fifo_write_arbiter dut (
      .clk(clk), .rst(rst), .req_valid_in(valid), .req_data_in(data),
      .req_ready_out(ready), .fifo_wren_out(wren), .fifo_wdata_out(wdata),
      .fifo_rden_in(rden), .fifo_full_in(full), .credits_out(credits), .error_out(err)
   );

   always begin
      #5;
      if (run) clk = ~clk;
   end

   function automatic logic [31:0] dat(input int i);
      return 32'hC0DE_0000 | i;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; run = 1'b0; valid = '0; rden = 1'b0; full = 1'b0;
      for (int i = 0; i < 4; i++) data[i*32 +: 32] = dat(i);
      #1 rst = 1'b1;
      #2;
      chk("rst_cred", credits, 32);
      chk("rst_wren", wren, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_err", err, 0);
      chk("rst_rdy", ready, 0);
      #3 rst = 1'b0; run = 1'b1;
      tick;
      valid = 4'hF;
      #1;
      for (int k = 0; k < 32; k++) begin
         chk("rr_rdy", ready, 32'(1 << (k % 4)));
         tick;
         chk("rr_wren", wren, 1);
         chk("rr_wdata", wdata, dat(k % 4));
         chk("rr_cred", credits, 32'(31 - k));
      end
      chk("empty_rdy", ready, 0);
      tick;
      chk("empty_wren", wren, 0);
      chk("empty_cred", credits, 0);
      rden = 1'b1;
      #1;
      chk("ret_rdy0", ready, 0);
      tick;
      rden = 1'b0;
      #1;
      chk("ret_cred1", credits, 1);
      chk("ret_rdy", ready, 4'b0001);
      tick;
      chk("ret_wren", wren, 1);
      chk("ret_wdata", wdata, dat(0));
      chk("ret_cred0", credits, 0);
      full = 1'b1;
      tick;
      full = 1'b0;
      chk("ovf_err", err, CHK ? 2'b01 : 2'b00);
      chk("ret_wren0", wren, 0);
      chk("ret_rdy_after", ready, 0);
      valid = '0;
      rden = 1'b1;
      repeat (33) tick;
      rden = 1'b0;
      chk("sat_cred", credits, 32);
      chk("unf_err", err, CHK ? 2'b11 : 2'b00);
      valid = 4'b0100;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("solo_rdy", ready, 4'b0100);
         tick;
         chk("solo_wdata", wdata, dat(2));
      end
      chk("solo_cred", credits, 29);
      valid = 4'b0101;
      #1;
      chk("wrap_rdy0", ready, 4'b0001);
      tick;
      chk("wrap_wdata0", wdata, dat(0));
      chk("wrap_cred0", credits, 28);
      chk("wrap_rdy2", ready, 4'b0100);
      rden = 1'b1;
      tick;
      rden = 1'b0;
      chk("wrap_wdata2", wdata, dat(2));
      chk("net0_cred", credits, 28);
      chk("wrap_rdy0b", ready, 4'b0001);
      tick;
      chk("wrap_wdata0b", wdata, dat(0));
      chk("wrap_cred1", credits, 27);
      chk("err_held", err, CHK ? 2'b11 : 2'b00);
      valid = 4'hF;
      tick;
      chk("burst_wren1", wren, 1);
      chk("burst_wdata1", wdata, dat(1));
      tick;
      chk("burst_wren2", wren, 1);
      #3 rst = 1'b1;
      #1;
      chk("mrst_wren", wren, 0);
      chk("mrst_cred", credits, 32);
      chk("mrst_wdata", wdata, 0);
      chk("mrst_err", err, 0);
      valid = 4'b0110;
      #1;
      chk("mrst_rdy", ready, 4'b0010);
      #1 rst = 1'b0;
      tick;
      chk("post_wren", wren, 1);
      chk("post_wdata", wdata, dat(1));
      chk("post_cred", credits, 31);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/kanagawa_fifo_write_arbiter.md
# kanagawa_fifo_write_arbiter

Round-robin arbiter that shares one FIFO write port among `NUM_REQ` requesters. It uses a credit counter to prevent FIFO overflow. It sits between producer pipelines and a single-clock Kanagawa FIFO, and accepts a request only when a credit guarantees a free entry. An optional checker raises sticky overflow and underflow flags for the port it drives.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 32: data width.
- `DEPTH`, default 32: FIFO capacity in entries; this is also the credit reset value.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid_in`  in  NUM_REQ  per-requester valid.
- `req_data_in`  in  NUM_REQ*WIDTH  requester i data at `[i*WIDTH +: WIDTH]`.
- `req_ready_out`  out  NUM_REQ  one-hot grant; transfer occurs when valid & ready.
- `fifo_wren_out`  out  1  registered FIFO write enable.
- `fifo_wdata_out`  out  WIDTH  registered FIFO write data.
- `fifo_rden_in`  in  1  FIFO consumer popped one entry; returns one credit.
- `fifo_full_in`  in  1  FIFO full flag; used only by the checker.
- `credits_out`  out  $clog2(DEPTH+1)  current free-entry credits.
- `error_out`  out  2  sticky: [0] overflow, [1] underflow.

## Operation
- State:
  - `credits` counter.
  - Round-robin pointer `ptr` (0..NUM_REQ-1).
  - Output register.
  - Error flags.
- Grant enable: `credits != 0`, evaluated on the registered value.
- Arbitration search order: indices `ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1`.
  - The first index with valid set receives `req_ready_out` = one-hot for that index.
  - With no valid or no credit, `req_ready_out` = 0.
- On a grant to index i:
  - `ptr <= (i+1) mod NUM_REQ`.
  - `fifo_wren_out <= 1`.
  - `fifo_wdata_out <=` data of requester i.
- Without a grant: `fifo_wren_out <= 0` and `fifo_wdata_out` holds its previous value.
- Credit update: `credits <= credits - grant_any + fifo_rden_in`.
  - Grant and rden in the same cycle: net 0.
  - rden with `credits == 0`: no grant that cycle; credits becomes 1.
  - rden with `credits == DEPTH`: credits saturate at DEPTH (underflow event).
  - Credits never go below 0, because a grant requires a nonzero credit.
- Requesters hold valid and data stable until accepted. The arbiter tolerates valid being withdrawn, and that requester is then simply not granted.
- Reset value of each output:
  - `req_ready_out`: 0 when idle.
  - `fifo_wren_out`: 0.
  - `fifo_wdata_out`: 0.
  - `credits_out`: DEPTH.
  - `error_out`: 2'b00.
  - `ptr`: 0.
- Reset mid-operation discards the in-flight write. The FIFO must be reset in the same domain reset.

## Timing
- Request-to-write latency: 1 cycle. Grant in cycle N gives `fifo_wren_out` high in cycle N+1.
- `req_ready_out` is combinational from `req_valid_in` and registered state only. There is no combinational path from `fifo_rden_in` or `fifo_full_in` to any output.
- The credit is consumed at grant time, so a write in flight is already accounted for.
- Throughput: one write per cycle while credits > 0. A fully drained FIFO sustains DEPTH back-to-back writes.
- `credits_out` reflects the registered counter; a returned credit is usable in the cycle after rden.
- Reset is asynchronous: all state clears immediately on `rst` rise, and the block resumes on the first `clk` edge after `rst` falls.

## Configuration
- `KANAGAWA_FIFO_ARB_CHECK_EN` defined:
  - `error_out[0]` sets on `fifo_wren_out & fifo_full_in`.
  - `error_out[1]` sets on `fifo_rden_in` while `credits == DEPTH`.
  - Both flags are sticky until `rst`. The checker logic is excluded from coverage.
- `KANAGAWA_FIFO_ARB_CHECK_EN` undefined:
  - `error_out` is tied to 2'b00 and `fifo_full_in` is unused.
  - Arbitration and credit behaviour are identical in both builds.

## Test plan
- **Reset:** assert `rst` with `clk` stopped → `credits_out`=32, `fifo_wren_out`=0, `error_out`=0, `req_ready_out`=0 immediately.
- **Fairness and credit limit:** NUM_REQ=4, DEPTH=32, all valid held, no rden → grants cycle 0,1,2,3,0,…. Exactly 32 writes occur, each with the granted requester's data. `req_ready_out` then stays 0 and `credits_out`=0.
- **Credit return:** at credits=0, pulse rden for 1 cycle → exactly one grant in the next cycle, to the next index in round-robin order; `credits_out` returns to 0.
- **Wrap-around:** only requester 2 valid for 3 cycles, so ptr=3. Then assert requester 0 alongside 2 → requester 0 granted first, then 2, then 0, alternating. Simultaneous grant and rden leaves `credits_out` unchanged.
- **Checker:** with the macro defined, force `fifo_full_in`=1 during a write → `error_out`=2'b01 next cycle and held. rden at credits=32 → `error_out[1]`=1 with credits still 32. Without the macro, the same stimulus leaves `error_out`=0.
- **Reset mid-burst:** assert `rst` asynchronously mid-cycle during back-to-back writes → `fifo_wren_out` drops immediately, `credits_out`=32, and after release the first grant goes to the lowest valid index at or after index 0.
